// File: rtl/bus_gate_arbiter_if.sv
// Bus gate arbitration interface: per-source requests and last-cycle flags
// going in, the one-hot gate select and status flags coming back out.
interface bus_gate_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  // Bus sources drive requests and observe the grant
  modport master (
    output req,
    output done,
    input  gnt,
    input  owner,
    input  busy,
    input  timeout
  );

  // The arbiter samples requests and owns the gate select
  modport slave (
    input  req,
    input  done,
    output gnt,
    output owner,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the shared 16-bit bus gate select. One source at a
// time gets a registered one-hot grant, holds it until it releases or the
// hold limit runs out, and every handover passes through one idle cycle so
// two sources never drive the bus in the same cycle.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic            Clk,
  input logic            Reset,
  bus_gate_arbiter_if.slave bus
);

  // A zero hold limit still needs a one-bit counter that simply saturates
  localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [3:0]       gnt_q,     gnt_d;
  logic [1:0]       owner_q,   owner_d;
  logic             busy_q,    busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic       winFound;
  logic [1:0] winIdx;
  logic [1:0] scanIdx;
  logic       ownerRelease;
  logic       holdExpired;

  // Pick the first requester at or after the round-robin pointer, wrapping 3 to 0
  always_comb begin
    winFound = 1'b0;
    winIdx   = 2'd0;
    scanIdx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scanIdx = ptr_q + 2'(k);
      if (!winFound && bus.req[scanIdx]) begin
        winFound = 1'b1;
        winIdx   = scanIdx;
      end
    end
  end

  // Release by the owner always beats the hold limit, so timeout stays quiet
  always_comb begin
    ownerRelease = !bus.req[owner_q] || bus.done[owner_q];
    holdExpired  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  end

  // Next-state logic: arbitrate when the bus is free, otherwise police the owner
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE, TURN: begin
        if (winFound) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winIdx;
          owner_d = winIdx;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end

      GRANT: begin
        if (ownerRelease || holdExpired) begin
          state_d   = TURN;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = owner_q + 2'd1;
          timeout_d = !ownerRelease;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the gate select immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Bench for bus_gate_arbiter: directed vector table, a few hand-written
// sequences, then random traffic against a behavioural model. Two copies are
// driven by the same stimulus, one with a hold limit of 4 and one unlimited.
module tb_bus_gate_arbiter;

  logic Clk;
  logic Reset;
  logic [3:0] reqTb;
  logic [3:0] doneTb;

  int compCount;
  int failCount;

  bus_gate_arbiter_if busA ();
  bus_gate_arbiter_if busB ();

  assign busA.req  = reqTb;
  assign busA.done = doneTb;
  assign busB.req  = reqTb;
  assign busB.done = doneTb;

  bus_gate_arbiter #(.MAX_HOLD(4)) dutA (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busA)
  );

  bus_gate_arbiter #(.MAX_HOLD(0)) dutB (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (busB)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard stop in case something ever stalls the stimulus
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       timeout;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Behavioural view of the arbiter: who holds the bus, for how long, and
  // where the next search starts. A free bus always arbitrates at the next edge.
  typedef struct {
    logic [3:0] gnt;
    int         owner;
    bit         timeout;
    int         held;
    int         nextStart;
  } model_t;

  model_t mA;
  model_t mB;

  function automatic model_t modelReset();
    model_t m;
    m.gnt       = 4'b0000;
    m.owner     = 0;
    m.timeout   = 1'b0;
    m.held      = 0;
    m.nextStart = 0;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, logic [3:0] r, logic [3:0] d, int maxHold);
    model_t n;
    bit found;
    int idx;
    n = m;
    n.timeout = 1'b0;
    if (m.gnt != 4'b0000) begin
      if (r[m.owner] == 1'b0 || d[m.owner] == 1'b1) begin
        n.gnt       = 4'b0000;
        n.nextStart = (m.owner + 1) % 4;
      end else if (maxHold != 0 && m.held >= maxHold) begin
        n.gnt       = 4'b0000;
        n.timeout   = 1'b1;
        n.nextStart = (m.owner + 1) % 4;
      end else begin
        n.held = m.held + 1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = (m.nextStart + k) % 4;
        if (!found && r[idx]) begin
          found   = 1'b1;
          n.gnt   = 4'b0000;
          n.gnt[idx] = 1'b1;
          n.owner = idx;
          n.held  = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] packExp(logic [3:0] g, logic [1:0] o, logic t);
    return {g, o, (g != 4'b0000), t};
  endfunction

  function automatic logic [7:0] packA();
    return {busA.gnt, busA.owner, busA.busy, busA.timeout};
  endfunction

  function automatic logic [7:0] packB();
    return {busB.gnt, busB.owner, busB.busy, busB.timeout};
  endfunction

  // Compare one packed {gnt, owner, busy, timeout} observation
  task automatic checkOutput(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s #%0d: got gnt=%b owner=%0d busy=%b timeout=%b, expected gnt=%b owner=%0d busy=%b timeout=%b",
               name, idx, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs just after an edge, then sample just after the following edge
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    reqTb  = r;
    doneTb = d;
    @(posedge Clk);
    #1;
  endtask

  // Hold reset across an edge, check the cleared state, release mid-cycle
  task automatic resetDut(input string name);
    reqTb  = 4'b0000;
    doneTb = 4'b0000;
    Reset  = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput({name, "_resetA"}, 0, packA(), 8'h00);
    checkOutput({name, "_resetB"}, 0, packB(), 8'h00);
    Reset = 1'b0;
    mA = modelReset();
    mB = modelReset();
  endtask

  function automatic void addVec(bit rst, logic [3:0] r, logic [3:0] d, logic [3:0] g,
                                 logic [1:0] o, logic t, string name);
    vec_t v;
    v.rst = rst; v.req = r; v.done = d; v.gnt = g; v.owner = o; v.timeout = t; v.name = name;
    vecs.push_back(v);
  endfunction

  logic [3:0] rndReq;
  logic [3:0] rndDone;

  initial begin
    compCount = 0;
    failCount = 0;
    Reset  = 1'b1;
    reqTb  = 4'b0000;
    doneTb = 4'b0000;
    mA = modelReset();
    mB = modelReset();

    // Single request, release by done, then idle
    addVec(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "single");
    addVec(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "single");
    addVec(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, "single");
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "single");
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "single");
    // Round robin with done in each owner's second cycle
    addVec(1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "rr");
    for (int s = 0; s < 4; s++) begin
      logic [3:0] oh;
      oh = 4'b0001 << s;
      if (s != 0) addVec(0, 4'b1111, 4'b0000, oh, 2'(s), 1'b0, "rr");
      addVec(0, 4'b1111, 4'b0000, oh, 2'(s), 1'b0, "rr");
      addVec(0, 4'b1111, oh, 4'b0000, 2'(s), 1'b0, "rr");
    end
    addVec(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "rr");
    // Hold limit of 4 with a lone continuous requester
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 4; c++)
        addVec((rep == 0 && c == 0), 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "hold");
      addVec(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, "hold");
    end
    // Done beats the hold limit, and the pointer wraps from 3 back to 0
    for (int c = 0; c < 4; c++)
      addVec((c == 0), 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0, "prec");
    addVec(0, 4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b1, "prec");
    for (int c = 0; c < 4; c++)
      addVec(0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0, "prec");
    addVec(0, 4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b0, "prec");
    addVec(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0, "prec");
    // Foreign done and non-owner requests are ignored; dropping req releases
    addVec(1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "drop");
    addVec(0, 4'b1011, 4'b0100, 4'b0010, 2'd1, 1'b0, "drop");
    addVec(0, 4'b1101, 4'b0100, 4'b0000, 2'd1, 1'b0, "drop");
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, "drop");

    foreach (vecs[i]) begin
      if (vecs[i].rst) resetDut(vecs[i].name);
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput(vecs[i].name, i, packA(),
                  packExp(vecs[i].gnt, vecs[i].owner, vecs[i].timeout));
    end

    // Unlimited hold: the owner keeps the bus well past any small counter range
    resetDut("unlim");
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("unlim", c, packB(), packExp(4'b0001, 2'd0, 1'b0));
    end

    // Asynchronous reset between edges while source 3 owns the bus
    resetDut("async");
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("async_grant", 0, packA(), packExp(4'b1000, 2'd3, 1'b0));
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("async_midcycle", 0, packA(), 8'h00);
    #2;
    Reset = 1'b0;
    applyStimulus(4'b1010, 4'b0000);
    checkOutput("async_regrant", 0, packA(), packExp(4'b0010, 2'd1, 1'b0));

    // Random traffic against the model, both hold settings at once
    resetDut("rand");
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 4; b++) begin
        rndReq[b]  = ($urandom_range(0, 3) != 0);
        rndDone[b] = ($urandom_range(0, 7) == 0);
      end
      applyStimulus(rndReq, rndDone);
      mA = modelStep(mA, rndReq, rndDone, 4);
      mB = modelStep(mB, rndReq, rndDone, 0);
      checkOutput("randA", c, packA(), packExp(mA.gnt, 2'(mA.owner), mA.timeout));
      checkOutput("randB", c, packB(), packExp(mB.gnt, 2'(mB.owner), mB.timeout));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", compCount, failCount);
    $finish;
  end

endmodule

// File: doc/bus_gate_arbiter.md
# bus_gate_arbiter

Round-robin arbiter that owns the one-hot gate select of the shared 16-bit processor bus. Four bus sources (index 0..3, matching one-hot gate select bits 0..3) raise requests. The arbiter grants exactly one at a time, holds the grant until the owner releases or a hold limit expires, then inserts one bus-idle turnaround cycle before the next owner. Its `gnt` output drives the 4-bit one-hot select of the bus tristate gate directly, so at most one source ever drives the bus.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive granted cycles per ownership. 0 means unlimited. Valid range 0..255.
- `Clk` input 1: system clock; all state changes on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `req` input 4: per-source bus request; level-sensitive.
- `done` input 4: per-source last-cycle flag. Only the current owner's bit is honoured.
- `gnt` output 4: registered one-hot grant, or 0000. Feeds the bus gate select.
- `owner` output 2: index of the current/last owner; valid when `busy`=1.
- `busy` output 1: high while any `gnt` bit is high.
- `timeout` output 1: one-cycle registered pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- States: IDLE, GRANT, TURN.
- Reset (async, any state, mid-grant included) forces:
  - state IDLE, `gnt`=0000, `owner`=0, `busy`=0, `timeout`=0;
  - round-robin pointer `ptr`=0, hold counter `cnt`=0.
- Arbitration, evaluated in IDLE and TURN:
  - Scan `req` starting at `ptr`, ascending, wrapping 3→0.
  - The first set bit wins. The next state is GRANT, with `gnt` set to the winner's one-hot value, `owner`=winner and `cnt`=1.
  - If no bit is set, the next state is IDLE.
- GRANT, when the owner's `req` is high:
  - The owner releases when `done[owner]`=1 or `req[owner]`=0 is sampled.
  - Otherwise, if `MAX_HOLD`≠0 and `cnt`==`MAX_HOLD`, the grant is revoked and `timeout` is set to 1 for the next cycle.
  - Otherwise `cnt` increments. `cnt` is sized $clog2(MAX_HOLD+1), minimum 1 bit, and saturates (no wrap) when `MAX_HOLD`=0.
- GRANT exit, on release or revocation:
  - next state TURN, `gnt`=0000, `ptr`=(`owner`+1) mod 4;
  - `owner` holds its value.
- TURN always lasts exactly one cycle with `gnt`=0000, then arbitrates as above. A revoked owner still requesting therefore gets lowest priority next round.
- `done` bits of non-owners are ignored. `req` changes of non-owners during GRANT have no effect.
- If `done` and the hold-limit condition occur in the same cycle, `done` takes precedence: `timeout` stays 0.
- `gnt` is never multi-hot. `busy` = OR of `gnt`, driven from a register.

## Timing
- Edge k samples `req` in IDLE → `gnt` is high from edge k until the release edge. Request-to-grant latency is 1 cycle.
- Owner asserts `done` during cycle m → `gnt` drops at edge m.
  - Earliest next grant to any source is at edge m+1, because of the single idle turnaround cycle.
- Maximum continuous grant with `MAX_HOLD`=N: N cycles. `gnt` drops at the edge ending the N-th granted cycle, and `timeout` is high for exactly the following cycle (the TURN cycle).
- Worst-case wait for a continuously requesting source: 3 × (N+1) cycles, plus arbitration.
- Outputs are all registered; no combinational path from `req`/`done` to `gnt`.

## Test plan
1. **Reset, then single request.** Reset, release, `req`=0100 at edge 3 → `gnt`=0100, `owner`=2 and `busy`=1 from edge 3. `done`=0100 in cycle 6 → `gnt`=0000 at edge 6. With `req`=0000 at edge 7 → stays IDLE.
2. **Round robin.** `req`=1111 held, each owner pulses `done` in its 2nd cycle → grant order 0001, 0010, 0100, 1000, 0001, with `gnt`=0000 for exactly one cycle between grants.
3. **Hold limit.** `MAX_HOLD`=4, `req`=0001 held, no `done` → `gnt`=0001 for 4 cycles, then 0000 with `timeout`=1 for one cycle, then 0001 again for 4 cycles.
4. **Precedence and pointer wrap.** `MAX_HOLD`=4, `req`=1001, owner 3 asserts `done` on its 4th cycle → `timeout`=0 and the next grant is 0001.
5. **Request drop and foreign done.** Owner 1 granted, `done`=0100 pulsed → grant holds. Then `req[1]` dropped → `gnt`=0000 next edge, `timeout`=0.
6. **Async reset mid-grant.** `Reset` asserted between edges while `gnt`=1000 → `gnt`=0000, `busy`=0 immediately. After release, `req`=1010 → first grant is 0010 (`ptr`=0).
